// File: rtl/alu_pkg.sv
// Shared definitions for the RV32M multi-cycle unit: funct3 codes,
// sequencer state encoding and the default datapath width.
package alu_pkg;

  localparam int XLEN = 32;

  // RV32M funct3 encodings
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiply / divide datapath.
// The 2*XLEN accumulator is shared by both operations:
//   multiply: upper half = partial product, lower half = remaining multiplier bits
//   divide:   upper half = remainder,       lower half = quotient (dividend shifts out the top)
module muldiv_step
  import alu_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic           is_div,
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   operand,
  output logic [2*W-1:0] acc_next
);

  logic [W:0] sum;
  logic [W:0] shifted;
  logic [W:0] trial;

  // Shift-add multiply step or restoring divide step
  always_comb begin
    sum      = {1'b0, acc[2*W-1:W]} + {1'b0, operand};
    shifted  = {acc[2*W-1:W], acc[W-1]};
    trial    = shifted - {1'b0, operand};
    acc_next = acc;
    if (is_div) begin
      // A borrow out of the trial subtract means the divisor did not fit: restore
      if (trial[W]) begin
        acc_next = {shifted[W-1:0], acc[W-2:0], 1'b0};
      end else begin
        acc_next = {trial[W-1:0], acc[W-2:0], 1'b1};
      end
    end else begin
      if (acc[0]) begin
        acc_next = {sum, acc[W-1:1]};
      end else begin
        acc_next = {1'b0, acc[2*W-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M sequencer: accepts one M-extension op, runs XLEN iterations on
// magnitudes, then applies sign correction and registers the result.
// Divide-by-zero and signed overflow bypass the iterations entirely.
module muldiv_sequencer
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  md_state_t        state_reg;
  logic [CW-1:0]    count_reg;
  logic [2:0]       op_reg;
  logic             neg_q_reg;     // negate product / quotient
  logic             neg_r_reg;     // negate remainder
  logic             special_reg;   // acc low half already holds the final value
  logic [XLEN-1:0]  operand_reg;   // |multiplicand| or |divisor|
  logic [2*XLEN-1:0] acc_reg;
  logic [2*XLEN-1:0] acc_next;

  logic             signed_a;
  logic             signed_b;
  logic             neg_a;
  logic             neg_b;
  logic [XLEN-1:0]  abs_a;
  logic [XLEN-1:0]  abs_b;
  logic             div_zero;
  logic             div_ovf;
  logic [XLEN-1:0]  special_val;
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]  quo_fixed;
  logic [XLEN-1:0]  rem_fixed;
  logic [XLEN-1:0]  fix_value;

  muldiv_step #(.W(XLEN)) u_step (
    .is_div   (is_div_op(op_reg)),
    .acc      (acc_reg),
    .operand  (operand_reg),
    .acc_next (acc_next)
  );

  // Operand decode at the accept edge: signedness, magnitudes, special cases
  always_comb begin
    signed_a    = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    signed_b    = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    neg_a       = signed_a && srcA[XLEN-1];
    neg_b       = signed_b && srcB[XLEN-1];
    abs_a       = neg_a ? -srcA : srcA;
    abs_b       = neg_b ? -srcB : srcB;
    div_zero    = is_div_op(op) && (srcB == '0);
    div_ovf     = ((op == MD_DIV) || (op == MD_REM)) &&
                  (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1);
    special_val = '0;
    if (div_zero) begin
      special_val = op[1] ? srcA : '1;
    end else if (div_ovf) begin
      special_val = op[1] ? '0 : srcA;
    end
  end

  // Sign fix-up and output selection from the finished accumulator
  always_comb begin
    prod_fixed = neg_q_reg ? -acc_reg : acc_reg;
    quo_fixed  = neg_q_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    rem_fixed  = neg_r_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
    fix_value  = '0;
    if (special_reg) begin
      fix_value = acc_reg[XLEN-1:0];
    end else begin
      case (op_reg)
        MD_MUL:                       fix_value = prod_fixed[XLEN-1:0];
        MD_MULH, MD_MULHSU, MD_MULHU: fix_value = prod_fixed[2*XLEN-1:XLEN];
        MD_DIV, MD_DIVU:              fix_value = quo_fixed;
        default:                      fix_value = rem_fixed;
      endcase
    end
  end

  // Sequencer FSM with registered busy/done/result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      op_reg      <= MD_MUL;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      special_reg <= 1'b0;
      operand_reg <= '0;
      acc_reg     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state_reg <= IDLE;
        count_reg <= '0;
        busy      <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              op_reg      <= op;
              neg_q_reg   <= neg_a ^ neg_b;
              neg_r_reg   <= neg_a;
              count_reg   <= '0;
              busy        <= 1'b1;
              special_reg <= div_zero || div_ovf;
              if (div_zero || div_ovf) begin
                acc_reg   <= {{XLEN{1'b0}}, special_val};
                state_reg <= FIX;
              end else begin
                // Multiply iterates over the multiplier, divide shifts the dividend
                acc_reg     <= {{XLEN{1'b0}}, is_div_op(op) ? abs_a : abs_b};
                operand_reg <= is_div_op(op) ? abs_b : abs_a;
                state_reg   <= CALC;
              end
            end
          end
          CALC: begin
            acc_reg   <= acc_next;
            count_reg <= count_reg + 1'b1;
            if (count_reg == CW'(XLEN - 1)) begin
              state_reg <= FIX;
            end
          end
          FIX: begin
            result    <= fix_value;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
